// File: rtl/timer_pkg.sv
// Shared definitions for the timer family: mode encodings and the prescaler
// width helper used to size the prescaler phase register.
package timer_pkg;

    typedef enum logic {
        TIMER_ONESHOT  = 1'b0,
        TIMER_PERIODIC = 1'b1
    } timer_mode_e;

    // A divide-by-1 prescaler still keeps a 1-bit phase register so the
    // sub-module has a single implementation for every ratio.
    function automatic int prescale_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/timer_prescale.sv
// Clock prescaler: raises tick on every DIV-th enabled clock.
// With DIV=1 the phase never leaves 0, so tick simply follows en.
module timer_prescale
    import timer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic reset,
    input  logic clock,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int            PW   = prescale_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] phase;

    assign tick = en && (phase == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            phase <= '0;
        end else if (en) begin
            phase <= tick ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/timer_core.sv
// Single-channel timer covering alarm, timeout and periodic pulse use cases,
// with prescaler, hold input and live remaining-tick readback.
module timer_core
    import timer_pkg::*;
#(
    parameter int W   = 8,
    parameter int DIV = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] value,
    input  logic         put,
    input  logic         mode,
    input  logic         hold,
    output logic         bell,
    output logic         full,
    output logic         act,
    output logic [W-1:0] count
);

    logic [W-1:0] period;
    timer_mode_e  run_mode;
    logic         run_en;
    logic         tick;

    assign run_en = act && !hold;

    timer_prescale #(
        .DIV(DIV)
    ) u_prescale (
        .reset(reset),
        .clock(clock),
        .clear(put),
        .en   (run_en),
        .tick (tick)
    );

    // A put always wins over a coincident tick, which is how a load on the
    // expiry edge swallows that bell.
    always_ff @(posedge clock) begin
        if (reset) begin
            bell     <= 1'b0;
            full     <= 1'b0;
            act      <= 1'b0;
            count    <= '0;
            period   <= '0;
            run_mode <= TIMER_ONESHOT;
        end else begin
            bell <= 1'b0;
            if (put) begin
                full <= 1'b0;
                if (value != '0) begin
                    count    <= value;
                    period   <= value;
                    run_mode <= timer_mode_e'(mode);
                    act      <= 1'b1;
                end else begin
                    count <= '0;
                    act   <= 1'b0;
                end
            end else if (tick) begin
                if (count > W'(1)) begin
                    count <= count - W'(1);
                end else begin
                    bell <= 1'b1;
                    full <= 1'b1;
                    if (run_mode == TIMER_PERIODIC) begin
                        count <= period;
                    end else begin
                        count <= '0;
                        act   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core: a DIV=1 and a DIV=4 instance share stimulus and are
// compared each cycle against a clock-count model of the timer behaviour.
module tb_timer_core;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] value = '0;
    logic       put   = 1'b0;
    logic       mode  = 1'b0;
    logic       hold  = 1'b0;

    logic       bell1, full1, act1;
    logic [7:0] count1;
    logic       bell4, full4, act4;
    logic [7:0] count4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    timer_core #(.W(8), .DIV(1)) u_div1 (
        .clock(clock), .reset(reset), .value(value), .put(put), .mode(mode),
        .hold(hold), .bell(bell1), .full(full1), .act(act1), .count(count1)
    );

    timer_core #(.W(8), .DIV(4)) u_div4 (
        .clock(clock), .reset(reset), .value(value), .put(put), .mode(mode),
        .hold(hold), .bell(bell4), .full(full4), .act(act4), .count(count4)
    );

    // Model tracks clocks remaining until the next expiry; the visible count
    // is that figure rounded up to whole ticks.
    localparam int DIVS [2] = '{1, 4};
    int mR   [2];
    int mPer [2];
    bit mRun [2];
    bit mPeriodic [2];
    bit mBell [2];
    bit mFull [2];

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            mBell[i] = 1'b0;
            if (reset) begin
                mR[i] = 0; mPer[i] = 0; mRun[i] = 1'b0;
                mPeriodic[i] = 1'b0; mFull[i] = 1'b0;
            end else if (put) begin
                mFull[i] = 1'b0;
                if (value != 0) begin
                    mRun[i]      = 1'b1;
                    mPeriodic[i] = mode;
                    mPer[i]      = int'(value);
                    mR[i]        = int'(value) * DIVS[i];
                end else begin
                    mRun[i] = 1'b0;
                    mR[i]   = 0;
                end
            end else if (mRun[i] && !hold) begin
                mR[i] = mR[i] - 1;
                if (mR[i] == 0) begin
                    mBell[i] = 1'b1;
                    mFull[i] = 1'b1;
                    if (mPeriodic[i]) mR[i] = mPer[i] * DIVS[i];
                    else mRun[i] = 1'b0;
                end
            end
        end
    end

    logic [21:0] obs, expv;
    assign obs  = {bell1, full1, act1, count1, bell4, full4, act4, count4};
    assign expv = {mBell[0], mFull[0], mRun[0], 8'((mR[0] + DIVS[0] - 1) / DIVS[0]),
                   mBell[1], mFull[1], mRun[1], 8'((mR[1] + DIVS[1] - 1) / DIVS[1])};

    task automatic do_reset();
        reset = 1'b1; put = 1'b0; hold = 1'b0; value = '0; mode = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if (obs !== 22'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, 22'd0);
        end
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL reset_model: got %h expected %h", obs, expv);
        end
        reset = 1'b0;
    endtask

    task automatic test_oneshot();
        int bellAt = -1;
        do_reset();
        put = 1'b1; value = 8'h19; mode = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clock);
            put = 1'b0;
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL oneshot cyc %0d: got %h expected %h", j, obs, expv);
            end
            if (bell1 && bellAt < 0) bellAt = j;
        end
        vectors++;
        if (bellAt != 25 || count1 !== 8'd0 || full1 !== 1'b1 || act1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL oneshot_timing: bell at %0d cnt %0d full %b act %b, expected 25 0 1 0",
                     bellAt, count1, full1, act1);
        end
    endtask

    task automatic test_periodic();
        int bells = 0;
        int expCnt [6] = '{3, 2, 1, 3, 2, 1};
        do_reset();
        put = 1'b1; value = 8'd3; mode = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            put = 1'b0;
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL periodic cyc %0d: got %h expected %h", j, obs, expv);
            end
            if (j < 6) begin
                vectors++;
                if (count1 !== 8'(expCnt[j]) || act1 !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL periodic_count cyc %0d: got %0d act %b expected %0d act 1",
                             j, count1, act1, expCnt[j]);
                end
            end
            if (bell1) begin
                bells++;
                vectors++;
                if (j % 3 != 0) begin
                    miscompares++;
                    $display("[TB] FAIL periodic_bell: bell at %0d expected multiple of 3", j);
                end
            end
        end
        vectors++;
        if (bells != 3) begin
            miscompares++;
            $display("[TB] FAIL periodic_bells: got %0d expected 3", bells);
        end
    endtask

    task automatic test_prescale();
        int bellAt = -1;
        do_reset();
        put = 1'b1; value = 8'd2; mode = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            put = 1'b0;
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL prescale cyc %0d: got %h expected %h", j, obs, expv);
            end
            vectors++;
            if (count4 !== ((j < 4) ? 8'd2 : (j < 8) ? 8'd1 : 8'd0)) begin
                miscompares++;
                $display("[TB] FAIL prescale_count cyc %0d: got %0d", j, count4);
            end
            if (bell4 && bellAt < 0) bellAt = j;
        end
        vectors++;
        if (bellAt != 8) begin
            miscompares++;
            $display("[TB] FAIL prescale_bell: got %0d expected 8", bellAt);
        end
    endtask

    task automatic test_hold();
        int bellAt = -1;
        do_reset();
        put = 1'b1; value = 8'd10; mode = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            put = 1'b0;
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL hold cyc %0d: got %h expected %h", j, obs, expv);
            end
            if (bell1 && bellAt < 0) bellAt = j;
            hold = (j >= 2 && j < 7);
        end
        vectors++;
        if (bellAt != 15) begin
            miscompares++;
            $display("[TB] FAIL hold_bell: got %0d expected 15", bellAt);
        end
        // Load while frozen, then release and time the expiry from release.
        hold = 1'b1; put = 1'b1; value = 8'd4;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            put = 1'b0;
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL hold_load cyc %0d: got %h expected %h", j, obs, expv);
            end
        end
        hold = 1'b0;
        bellAt = -1;
        for (int j = 1; j < 9; j++) begin
            @(negedge clock);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL hold_release cyc %0d: got %h expected %h", j, obs, expv);
            end
            if (bell1 && bellAt < 0) bellAt = j;
        end
        vectors++;
        if (bellAt != 4) begin
            miscompares++;
            $display("[TB] FAIL hold_release_bell: got %0d expected 4", bellAt);
        end
    endtask

    task automatic test_retrigger();
        int bells = 0;
        int bellAt = -1;
        do_reset();
        put = 1'b1; value = 8'd10; mode = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL retrigger cyc %0d: got %h expected %h", j, obs, expv);
            end
            if (bell1) begin bells++; bellAt = j; end
            put = (j == 5);
            value = 8'd4;
        end
        vectors++;
        if (bells != 1 || bellAt != 10) begin
            miscompares++;
            $display("[TB] FAIL retrigger_bell: got %0d bells at %0d expected 1 at 10", bells, bellAt);
        end
    endtask

    task automatic test_cancel();
        int bells = 0;
        do_reset();
        put = 1'b1; value = 8'd10; mode = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(negedge clock);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL cancel cyc %0d: got %h expected %h", j, obs, expv);
            end
            if (bell1 || bell4) bells++;
            if (j >= 4) begin
                vectors++;
                if (act1 !== 1'b0 || full1 !== 1'b0 || count1 !== 8'd0) begin
                    miscompares++;
                    $display("[TB] FAIL cancel_state cyc %0d: act %b full %b cnt %0d expected 0 0 0",
                             j, act1, full1, count1);
                end
            end
            put = (j == 3);
            value = 8'd0;
        end
        vectors++;
        if (bells != 0) begin
            miscompares++;
            $display("[TB] FAIL cancel_bells: got %0d expected 0", bells);
        end
    endtask

    task automatic test_put_on_expiry();
        do_reset();
        put = 1'b1; value = 8'd3; mode = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL put_expiry cyc %0d: got %h expected %h", j, obs, expv);
            end
            if (j == 3) begin
                vectors++;
                if (bell1 !== 1'b0 || count1 !== 8'd5 || act1 !== 1'b1 || full1 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL put_expiry_load: bell %b cnt %0d act %b full %b expected 0 5 1 0",
                             bell1, count1, act1, full1);
                end
            end
            put = (j == 2);
            value = 8'd5;
        end
    endtask

    task automatic test_reset_midrun();
        int bells = 0;
        do_reset();
        put = 1'b1; value = 8'd10; mode = 1'b0;
        for (int j = 0; j < 45; j++) begin
            @(negedge clock);
            put = 1'b0;
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL reset_midrun cyc %0d: got %h expected %h", j, obs, expv);
            end
            if (j == 5) begin
                vectors++;
                if (obs !== 22'd0) begin
                    miscompares++;
                    $display("[TB] FAIL reset_midrun_clear: got %h expected %h", obs, 22'd0);
                end
            end
            if (j >= 5 && (bell1 || bell4)) bells++;
            reset = (j == 4);
        end
        vectors++;
        if (bells != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_midrun_bells: got %0d expected 0", bells);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int j = 0; j < 1500; j++) begin
            @(negedge clock);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("[TB] FAIL random cyc %0d: got %h expected %h", j, obs, expv);
            end
            reset = ($urandom_range(0, 199) == 0);
            put   = ($urandom_range(0, 11) == 0);
            value = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 12));
            mode  = 1'($urandom_range(0, 1));
            hold  = ($urandom_range(0, 3) == 0);
        end
        reset = 1'b0; put = 1'b0; hold = 1'b0;
    endtask

    initial begin
        $display("[TB] timer_core bench start");
        test_reset();
        test_oneshot();
        test_periodic();
        test_prescale();
        test_hold();
        test_retrigger();
        test_cancel();
        test_put_on_expiry();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_core.md
# timer_core

Parametrised single-channel timer unifying alarm, timeout and pulse behaviour in one block. Adds configurable counter width, a clock prescaler, a periodic auto-reload mode, a hold (pause) input and a live count readback. Sits on the same `value`/`put` load interface as the existing timer primitives and replaces them in new designs.

## Interface
- `W`, 8: width of `value` and of the tick counter.
- `DIV`, 1: prescaler ratio, ≥1; one counter tick every `DIV` clocks.
- `clock` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `value` in W: load value N, in ticks; sampled when `put`=1.
- `put` in 1: load/start strobe; one cycle high.
- `mode` in 1: 0 = one-shot, 1 = periodic; latched with `put`.
- `hold` in 1: while high, prescaler and counter are frozen.
- `bell` out 1: one-cycle pulse on each expiry.
- `full` out 1: level; set on first expiry, held until `put` or `reset`.
- `act` out 1: level; high while the timer is running.
- `count` out W: remaining ticks until next expiry.

## Operation
- Reset: `bell`=0, `full`=0, `act`=0, `count`=0, prescaler=0, latched period=0, latched mode=0.
- `put` with N≠0: `count`←N, period←N, mode latched, prescaler←0, `act`←1, `full`←0, `bell`←0. Retriggers if already running; restarts an expired periodic timer.
- `put` with N=0: cancel. `act`←0, `full`←0, `count`←0, `bell`←0; no event is generated.
- Tick: prescaler increments each clock while `act`=1 and `hold`=0. A tick occurs on the clock where the prescaler reaches `DIV`−1; the prescaler then wraps to 0. When `DIV`=1, every running, unheld clock is a tick.
- On a tick with `count`>1, `count` decrements.
- On a tick with `count`=1, the timer expires. `bell`←1 for one cycle and `full`←1.
  - One-shot: `count`←0 and `act`←0.
  - Periodic: `count`←period and `act` stays 1.
- `hold` does not mask `put`. A put under hold loads the timer, but counting starts only once `hold` falls.
- `hold` while idle has no effect.
- Priority: `reset` > `put` > tick.
  - `put` coinciding with an expiry tick suppresses that `bell` and applies the load.
- All outputs are registered. There is no combinational path from any input to any output.

## Timing
- Put sampled at edge k, N≥1, no hold:
  - `bell` is high in the cycle after edge k+N·DIV, for exactly one cycle.
  - `act` is high from edge k until edge k+N·DIV (one-shot).
  - `full` rises at the same edge as `bell`.
- Periodic: bells follow at k+N·DIV, k+2N·DIV, and so on; `act` never drops.
- Hold for H cycles while running delays every subsequent expiry by exactly H cycles.
- Counter never wraps: the minimum non-cancel load is 1, and the maximum is 2^W−1 ticks.
- Reset mid-run: all outputs are 0 after the reset edge, and no pending `bell` is emitted.

## Structure
- Shared package `timer_pkg`:
  - mode encodings `TIMER_ONESHOT`=0 and `TIMER_PERIODIC`=1;
  - a helper that computes the prescaler width as clog2(`DIV`), minimum 1.
- Sub-module `timer_prescale`:
  - params `DIV`;
  - ports `reset`, `clock`, `clear`, `en`, `tick`;
  - `tick` is combinational from its registered state;
  - `DIV`=1 degenerates to `tick`=`en`.
- `timer_core` holds the counter, period register, mode latch and the output registers.

## Test plan
- W=8, DIV=1, one-shot, value=8'h19, put at edge k → `bell` for one cycle after edge k+25; `act` high for 25 cycles; `full`=1 from k+25 on; `count` reads 0.
- Periodic, value=3, DIV=1 → `bell` at k+3, k+6 and k+9; `act` stays 1; `count` shows sequence 3,2,1,3,2,1; `full` set at k+3.
- DIV=4, value=2 → `bell` at k+8; `count` decrements only at k+4 and k+8.
- Hold: value=10, `hold` high for 5 cycles starting k+3 → `bell` at k+15. A put of value=4 under hold, followed by a release of `hold`, gives `bell` 4 cycles after release.
- Retrigger and cancel:
  - value=10, second put of value=4 at k+6 → exactly one `bell`, at k+10.
  - Put of value=0 mid-run → `act`=0, `full`=0, no `bell`.
- Priority and reset:
  - `put` on the expiry edge → `bell` suppressed and the new count loaded.
  - `reset` at k+5 of a value=10 run → all outputs 0 and no `bell` thereafter.
